// File: rtl/hybrid_adder_pipe.sv
// Segmented carry-lookahead adder/subtractor: one SEG-bit lookahead segment per
// pipeline stage, registered inter-segment carry, skewed operands, valid/ready flow.
module hybrid_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("hybrid_adder_pipe: WIDTH must be a positive multiple of SEG");
  end

  function automatic logic [SEG:0] lookahead(input logic [SEG-1:0] p,
                                             input logic [SEG-1:0] g,
                                             input logic           c0);
    logic [SEG:0] c;
    c[0] = c0;
    for (int i = 0; i < SEG; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return c;
  endfunction

  logic             en;
  logic [WIDTH-1:0] y_eff;
  logic             ovf_q;

  // One global enable: the whole pipe advances or the whole pipe holds.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign y_eff    = sub ? ~y : y;

  for (genvar gi = 0; gi < NSEG; gi++) begin : stage
    localparam int LO = gi * SEG;

    logic             v_in;
    logic             c_in;
    logic [SEG-1:0]   a;
    logic [SEG-1:0]   b;
    logic [SEG-1:0]   p;
    logic [SEG:0]     carry;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_d;
    logic             v_q;
    logic             c_q;
    logic [WIDTH-1:0] sum_q;

    if (gi == 0) begin : g_src
      assign v_in   = in_valid;
      assign a      = x[SEG-1:0];
      assign b      = y_eff[SEG-1:0];
      assign c_in   = sub | cin;
      assign sum_in = '0;
    end else begin : g_src
      assign v_in   = stage[gi-1].v_q;
      assign a      = stage[gi-1].g_ops.opx_q[SEG-1:0];
      assign b      = stage[gi-1].g_ops.opy_q[SEG-1:0];
      assign c_in   = stage[gi-1].c_q;
      assign sum_in = stage[gi-1].sum_q;
    end

    assign p     = a ^ b;
    assign carry = lookahead(p, a & b, c_in);
    assign sum_d = sum_in | (WIDTH'(p ^ carry[SEG-1:0]) << LO);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_in;
        c_q   <= carry[SEG];
        sum_q <= sum_d;
      end
    end

    // Operand segments not yet consumed ride along, shifted down one segment per stage.
    if (gi < NSEG - 1) begin : g_ops
      logic [WIDTH-1:0] xr_in;
      logic [WIDTH-1:0] yr_in;
      logic [WIDTH-1:0] opx_q;
      logic [WIDTH-1:0] opy_q;

      if (gi == 0) begin : g_ld
        assign xr_in = x >> SEG;
        assign yr_in = y_eff >> SEG;
      end else begin : g_ld
        assign xr_in = stage[gi-1].g_ops.opx_q >> SEG;
        assign yr_in = stage[gi-1].g_ops.opy_q >> SEG;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opx_q <= '0;
          opy_q <= '0;
        end else if (en) begin
          opx_q <= xr_in;
          opy_q <= yr_in;
        end
      end
    end

    if (gi == NSEG - 1) begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     ovf_q <= 1'b0;
        else if (en) ovf_q <= carry[SEG] ^ carry[SEG-1];
      end
    end
  end

  assign out_valid = stage[NSEG-1].v_q;
  assign s         = stage[NSEG-1].sum_q;
  assign cout      = stage[NSEG-1].c_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_hybrid_adder_pipe.sv
// Randomized and directed bench for hybrid_adder_pipe against an integer-arithmetic model.
module tb_hybrid_adder_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  hybrid_adder_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [17:0] exp_q[$];
  int          n_pass = 0;
  int          n_checks = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic        stall_prev = 1'b0;
  logic [17:0] held = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Plain integer arithmetic: unsigned for sum/carry, signed range test for overflow.
  function automatic logic [17:0] ref_model(input logic [15:0] xx, input logic [15:0] yy,
                                            input logic ci, input logic sb);
    int ux, uy, sx, sy, u, sr;
    logic [15:0] sum;
    logic co, ov;
    ux = int'(xx);
    uy = int'(yy);
    sx = int'($signed(xx));
    sy = int'($signed(yy));
    if (sb) begin
      u  = ux - uy;
      co = (ux >= uy);
      sr = sx - sy;
    end else begin
      u  = ux + uy + int'(ci);
      co = (u >= 65536);
      sr = sx + sy + int'(ci);
    end
    sum = u[15:0];
    ov  = (sr > 32767) || (sr < -32768);
    return {ov, co, sum};
  endfunction

  task automatic tick(input logic iv, input logic [15:0] xx, input logic [15:0] yy,
                      input logic ci, input logic sb, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = iv;
    x         = xx;
    y         = yy;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    #1;
    if (stall_prev) check("hold", {14'd0, ovf, cout, s}, {14'd0, held});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious", {31'd0, out_valid}, 32'd0);
      else begin
        check("result", {14'd0, ovf, cout, s}, {14'd0, exp_q.pop_front()});
        n_out++;
      end
    end
    stall_prev = out_valid && !out_ready;
    held       = {ovf, cout, s};
    acc        = in_valid && in_ready;
    if (acc) begin
      exp_q.push_back(ref_model(xx, yy, ci, sb));
      n_acc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    n_acc = n_acc - exp_q.size();
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic measure(input logic [15:0] xx, input logic [15:0] yy,
                         input logic ci, input logic sb);
    logic acc;
    int   lat;
    tick(1'b1, xx, yy, ci, sb, 1'b1, acc);
    check("lat_accept", {31'd0, acc}, 32'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
      if (out_valid) lat = i;
    end
    check("latency", lat, 32'd4);
  endtask

  logic [15:0] dir_x [4] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
  logic [15:0] dir_y [4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
  logic        dir_sb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    logic        acc;
    int          idx;
    int          base_out;
    logic [15:0] sx_d [8];
    logic [15:0] sy_d [8];

    do_reset();

    measure(16'h1234, 16'h4321, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) tick(1'b1, dir_x[i], dir_y[i], 1'b0, dir_sb[i], 1'b1, acc);
    for (int i = 0; i < 6; i++) tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);

    // Eight back-to-back beats with a three-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      sx_d[i] = 16'($urandom);
      sy_d[i] = 16'($urandom);
    end
    idx = 0;
    base_out = n_out;
    for (int c = 0; c < 40; c++) begin
      logic stall;
      stall = (c >= 5 && c < 8);
      tick(idx < 8, sx_d[idx % 8], sy_d[idx % 8], 1'(idx % 2), 1'(idx / 4), !stall, acc);
      if (acc) idx++;
      if (stall) begin
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    check("stream_count", n_out - base_out, 32'd8);

    // Reset with three beats in flight: none of them may ever surface.
    for (int i = 0; i < 3; i++)
      tick(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, acc);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end
    measure(16'($urandom), 16'($urandom), 1'b1, 1'b0);

    for (int c = 0; c < 400; c++)
      tick($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 3) != 0, acc);
    for (int c = 0; c < 12; c++) tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
    check("drain_empty", exp_q.size(), 32'd0);
    check("beats_in_out", n_out, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

endmodule
